// File: rtl/mem_access_unit.sv
// Memory stage: drives word loads/stores over a req/ack data port, stalls
// upstream stages while an access is outstanding, aborts on timeout and owns
// the MEM/WB pipeline register.
module mem_access_unit #(
    parameter int unsigned DMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] EX_MEM_ALU_result,
    input  logic [31:0] EX_MEM_rs2_data,
    input  logic [4:0]  EX_MEM_rd,
    input  logic        EX_MEM_memread,
    input  logic        EX_MEM_memwrite,
    input  logic        EX_MEM_memtoreg,
    input  logic        EX_MEM_regwrite,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        MEM_stall,
    output logic        MEM_fault,
    output logic [4:0]  MEM_WB_rd,
    output logic [31:0] MEM_WB_result,
    output logic        MEM_WB_regwrite
);

    localparam int unsigned CntWidth = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT) : 1;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(DMEM_TIMEOUT - 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                fault_q, fault_d;
    logic [4:0]          wb_rd_q, wb_rd_d;
    logic [31:0]         wb_result_q, wb_result_d;
    logic                wb_regwrite_q, wb_regwrite_d;
    logic                stall;

    logic access;
    logic aligned;
    logic is_load;
    logic rd_writes;

    assign access    = EX_MEM_memread | EX_MEM_memwrite;
    assign aligned   = (EX_MEM_ALU_result[1:0] == 2'b00);
    // Read+write together is treated as a store, so it never selects load data.
    assign is_load   = EX_MEM_memread & ~EX_MEM_memwrite;
    // x0 is never written back.
    assign rd_writes = EX_MEM_regwrite & (EX_MEM_rd != 5'd0);

    // Next-state, port request and MEM/WB update logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        fault_d       = 1'b0;
        wb_rd_d       = wb_rd_q;
        wb_result_d   = wb_result_q;
        wb_regwrite_d = 1'b0;
        stall         = 1'b0;

        case (state_q)
            StIdle: begin
                if (access && aligned) begin
                    req_d   = 1'b1;
                    we_d    = EX_MEM_memwrite;
                    addr_d  = EX_MEM_ALU_result;
                    wdata_d = EX_MEM_rs2_data;
                    cnt_d   = '0;
                    stall   = 1'b1;
                    state_d = StBusy;
                end else if (access) begin
                    // Misaligned: retire as a bubble and flag the fault.
                    fault_d     = 1'b1;
                    wb_rd_d     = EX_MEM_rd;
                    wb_result_d = EX_MEM_ALU_result;
                end else begin
                    wb_rd_d       = EX_MEM_rd;
                    wb_result_d   = EX_MEM_ALU_result;
                    wb_regwrite_d = rd_writes;
                end
            end
            StBusy: begin
                if (dmem_ack) begin
                    req_d         = 1'b0;
                    cnt_d         = '0;
                    wb_rd_d       = EX_MEM_rd;
                    wb_result_d   = (EX_MEM_memtoreg && is_load) ? dmem_rdata
                                                                 : EX_MEM_ALU_result;
                    wb_regwrite_d = rd_writes;
                    state_d       = StIdle;
                end else if (cnt_q == CntLast) begin
                    // No ack in time: drop the request and retire as a bubble.
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    fault_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                    stall = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            fault_q       <= 1'b0;
            wb_rd_q       <= '0;
            wb_result_q   <= '0;
            wb_regwrite_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_q         <= req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            fault_q       <= fault_d;
            wb_rd_q       <= wb_rd_d;
            wb_result_q   <= wb_result_d;
            wb_regwrite_q <= wb_regwrite_d;
        end
    end

    assign dmem_req        = req_q;
    assign dmem_we         = we_q;
    assign dmem_addr       = addr_q;
    assign dmem_wdata      = wdata_q;
    assign MEM_fault       = fault_q;
    assign MEM_WB_rd       = wb_rd_q;
    assign MEM_WB_result   = wb_result_q;
    assign MEM_WB_regwrite = wb_regwrite_q;
    assign MEM_stall       = stall;

endmodule
